// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter that serialises set/reset requests onto one gated SR latch,
// pulsing EN with S/R held stable and checking the latch readback afterwards.
module sr_latch_arbiter #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned PULSE_LEN = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] op,
   input  logic            q_in,
   output logic            s,
   output logic            r,
   output logic            en,
   output logic [NREQ-1:0] ack,
   output logic            busy,
   output logic            q_shadow,
   output logic            err
);

   localparam int unsigned IW = $clog2(NREQ);
   localparam int unsigned CW = 4;
   localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_LEN - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      PULSE   = 3'd2,
      RELEASE = 3'd3,
      CHECK   = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            op_q, op_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            valid_q, valid_d;
   logic            shadow_d;
   logic            err_d;
   logic            s_d, r_d, en_d, busy_d;
   logic [NREQ-1:0] ack_d;
   logic            found;
   logic [IW-1:0]   gnt_idx;

   // (base + off) mod NREQ for off < NREQ, avoiding a general modulo
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= NREQ) sum = sum - NREQ;
      return IW'(sum);
   endfunction

   // Round-robin search starting at ptr
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (!found && req[wrap_add(ptr_q, k)]) begin
            found   = 1'b1;
            gnt_idx = wrap_add(ptr_q, k);
         end
      end
   end

   // Next state, captured operation, shadow/err bookkeeping and next outputs
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      op_d     = op_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      valid_d  = valid_q;
      shadow_d = q_shadow;
      err_d    = err;
      s_d      = 1'b0;
      r_d      = 1'b0;
      en_d     = 1'b0;
      ack_d    = '0;

      case (state_q)
         IDLE: begin
            if (found) begin
               idx_d = gnt_idx;
               op_d  = op[gnt_idx];
               ptr_d = wrap_add(gnt_idx, 1);
               if (valid_q && (op[gnt_idx] == q_shadow)) begin
                  // Latch already holds the requested value: skip straight to CHECK
                  state_d = CHECK;
                  if (q_in != q_shadow) err_d = 1'b1;
               end else begin
                  state_d = SETUP;
               end
            end
         end
         SETUP: begin
            state_d = PULSE;
            cnt_d   = '0;
         end
         PULSE: begin
            if (cnt_q == CNT_LAST) state_d = RELEASE;
            else                   cnt_d   = cnt_q + CW'(1);
         end
         RELEASE: begin
            // Shadow commits on CHECK entry so err is visible alongside ack
            state_d  = CHECK;
            shadow_d = op_q;
            valid_d  = 1'b1;
            if (q_in != op_q) err_d = 1'b1;
         end
         CHECK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      case (state_d)
         SETUP, RELEASE: begin
            s_d = op_d;
            r_d = ~op_d;
         end
         PULSE: begin
            s_d  = op_d;
            r_d  = ~op_d;
            en_d = 1'b1;
         end
         CHECK: begin
            ack_d = NREQ'(1) << idx_d;
         end
         default: begin
            s_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         op_q     <= 1'b0;
         ptr_q    <= '0;
         cnt_q    <= '0;
         valid_q  <= 1'b0;
         q_shadow <= 1'b0;
         err      <= 1'b0;
         s        <= 1'b0;
         r        <= 1'b0;
         en       <= 1'b0;
         ack      <= '0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         op_q     <= op_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         q_shadow <= shadow_d;
         err      <= err_d;
         s        <= s_d;
         r        <= r_d;
         en       <= en_d;
         ack      <= ack_d;
         busy     <= busy_d;
      end
   end

   // Latch-safety invariants
   a_no_sr_both : assert property (@(posedge clk) disable iff (!rst_n) !(s && r));
   a_ack_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
   a_en_drive   : assert property (@(posedge clk) disable iff (!rst_n) en |-> (s ^ r));

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Bench for sr_latch_arbiter: directed vector table, corner sequences and random
// transactions against a transaction-level model of the arbiter and latch.
module tb_sr_latch_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned P    = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] op = '0;
   logic       q_in;
   logic       s, r, en, busy, q_shadow, err;
   logic [3:0] ack;

   logic lq = 1'b0;
   bit   stuck = 1'b0;

   int checks = 0;
   int failures = 0;

   int   m_ptr;
   logic m_shadow, m_valid, m_err;

   sr_latch_arbiter #(.NREQ(NREQ), .PULSE_LEN(P)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op(op), .q_in(q_in),
      .s(s), .r(r), .en(en), .ack(ack), .busy(busy),
      .q_shadow(q_shadow), .err(err)
   );

   always #5 clk = ~clk;

   // Gated SR latch, with optional stuck-at-0 readback
   always @(negedge clk) if (en) begin
      if (s)      lq <= 1'b1;
      else if (r) lq <= 1'b0;
   end
   assign q_in = stuck ? 1'b0 : lq;

   typedef struct {
      logic [3:0] req;
      logic [3:0] op;
      logic [3:0] drop;
      logic [3:0] ack;
      int         lat;
      logic       shadow;
   } vec_t;
   vec_t tbl [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, want);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_shadow = 1'b0; m_valid = 1'b0; m_err = 1'b0;
   endtask

   // One transaction at the level of the requirements: pick, elide, commit, compare
   task automatic model_step(input logic [3:0] rq, input logic [3:0] opv,
                             output logic [3:0] e_ack, output int e_lat, output logic e_shadow);
      int   g = 0;
      bit   hit = 0;
      bit   elided;
      logic qa;
      for (int k = 0; k < int'(NREQ); k++) begin
         int j = (m_ptr + k) % int'(NREQ);
         if (!hit && rq[j]) begin hit = 1; g = j; end
      end
      elided   = m_valid && (opv[g] == m_shadow);
      e_shadow = elided ? m_shadow : opv[g];
      qa       = stuck ? 1'b0 : (elided ? lq : opv[g]);
      if (qa != e_shadow) m_err = 1'b1;
      m_shadow = e_shadow;
      m_valid  = 1'b1;
      m_ptr    = (g + 1) % int'(NREQ);
      e_ack    = 4'(1 << g);
      e_lat    = elided ? 1 : int'(P) + 3;
   endtask

   // Called one step after an edge with the DUT idle and req/op already driven
   task automatic run_txn(input string nm, input logic [3:0] e_ack, input int e_lat,
                          input logic e_shadow, input logic [3:0] drop, input bit hold);
      int   k = 0;
      int   en_cnt = 0;
      bit   acked = 0;
      logic ps = 1'b0, pr = 1'b0, pe = 1'b0;
      @(posedge clk); #1;
      chk({nm, "_grant"}, busy, 1);
      if (!busy) return;
      while (!acked && k < int'(P) + 8) begin
         chk({nm, "_s_and_r"}, s & r, 0);
         chk({nm, "_sr_change"}, ((s != ps) || (r != pr)) && (en || pe), 0);
         if (en) begin
            en_cnt++;
            chk({nm, "_sr_drive"}, {s, r}, {e_shadow, ~e_shadow});
         end
         if (ack != 4'b0) begin
            acked = 1;
            chk({nm, "_ack"}, ack, e_ack);
            chk({nm, "_latency"}, k + 1, e_lat);
            chk({nm, "_q_shadow"}, q_shadow, e_shadow);
            chk({nm, "_err"}, err, m_err);
         end
         ps = s; pr = r; pe = en;
         if (k == 0) req = req & ~drop;
         if (!acked) begin
            @(posedge clk); #1;
            k++;
         end
      end
      chk({nm, "_ack_seen"}, acked, 1);
      chk({nm, "_en_cycles"}, en_cnt, (e_lat == 1) ? 0 : int'(P));
      if (!hold) req = req & ~e_ack;
      @(posedge clk); #1;
      chk({nm, "_idle_gap"}, busy, 0);
      chk({nm, "_ack_clear"}, ack, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] ea, dr;
      int         el;
      logic       es;

      tbl[0] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 5, 1'b1};
      tbl[1] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 1'b1};
      tbl[2] = '{4'b0011, 4'b0000, 4'b0000, 4'b0001, 5, 1'b0};
      tbl[3] = '{4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 1'b0};
      tbl[4] = '{4'b1010, 4'b1000, 4'b0000, 4'b1000, 5, 1'b1};
      tbl[5] = '{4'b0010, 4'b0000, 4'b0010, 4'b0010, 5, 1'b0};
      tbl[6] = '{4'b1001, 4'b0001, 4'b0000, 4'b1000, 1, 1'b0};
      tbl[7] = '{4'b1111, 4'b1111, 4'b0000, 4'b0001, 5, 1'b1};

      model_reset();
      #12;
      chk("rst_s", s, 0);
      chk("rst_r", r, 0);
      chk("rst_en", en, 0);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_q_shadow", q_shadow, 0);
      chk("rst_err", err, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         req = tbl[i].req;
         op  = tbl[i].op;
         model_step(req, op, ea, el, es);
         run_txn($sformatf("vec%0d", i), tbl[i].ack, tbl[i].lat, tbl[i].shadow, tbl[i].drop, 0);
      end

      // Readback stuck at 0 during a set, then err must stay through good ops
      req = 4'b0001; op = 4'b0000;
      model_step(req, op, ea, el, es);
      run_txn("pre_clear", ea, el, es, 4'b0, 0);
      stuck = 1'b1;
      req = 4'b0010; op = 4'b0010;
      model_step(req, op, ea, el, es);
      run_txn("stuck_set", ea, el, es, 4'b0, 0);
      chk("err_after_stuck", err, 1);
      stuck = 1'b0;
      req = 4'b0100; op = 4'b0000;
      model_step(req, op, ea, el, es);
      run_txn("good_clr", ea, el, es, 4'b0, 0);
      req = 4'b1000; op = 4'b1000;
      model_step(req, op, ea, el, es);
      run_txn("good_set", ea, el, es, 4'b0, 0);
      chk("err_sticky", err, 1);

      // Reset in the middle of the EN pulse
      req = 4'b0001; op = {3'b000, ~m_shadow};
      @(posedge clk); #1;
      chk("abort_grant", busy, 1);
      @(posedge clk); #1;
      chk("abort_pulse_en", en, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_en", en, 0);
      chk("abort_s", s, 0);
      chk("abort_r", r, 0);
      chk("abort_busy", busy, 0);
      chk("abort_ack", ack, 0);
      chk("abort_err", err, 0);
      chk("abort_q_shadow", q_shadow, 0);
      model_reset();
      req = 4'b0000;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort_no_ack", ack, 0);
      end
      req = 4'b0001;
      model_step(req, op, ea, el, es);
      run_txn("post_abort", ea, el, es, 4'b0, 0);

      // All requesters held, alternating ops: strict rotation 0,1,2,3,0
      rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      model_reset();
      req = 4'b1111; op = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         model_step(req, op, ea, el, es);
         run_txn($sformatf("rr%0d", i), 4'(1 << (i % 4)), el, es, 4'b0, 1);
      end
      req = 4'b0000;
      @(posedge clk); #1;

      for (int n = 0; n < 150; n++) begin
         req   = 4'($urandom_range(1, 15));
         op    = 4'($urandom);
         stuck = ($urandom_range(0, 9) == 0);
         dr    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         model_step(req, op, ea, el, es);
         run_txn($sformatf("rnd%0d", n), ea, el, es, dr, 0);
      end
      stuck = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sr_latch_arbiter.md
SR_LATCH_ARBITER -- requirements
Module: sr_latch_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL have parameter PULSE_LEN, default 2, cycles EN is held high per operation (1..15).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester operation request, level, held until ack.
- op  input  NREQ  per-requester operation: 1 = set, 0 = reset; valid while req high.
- q_in  input  1  Q feedback from the controlled SR latch.
- s  output  1  latch S drive.
- r  output  1  latch R drive.
- en  output  1  latch EN drive.
- ack  output  NREQ  one-cycle completion pulse, one-hot.
- busy  output  1  high in any state other than IDLE.
- q_shadow  output  1  last value committed to the latch.
- err  output  1  sticky readback mismatch flag.

Function
REQ-004 The block SHALL implement states IDLE, SETUP, PULSE, RELEASE, CHECK.
REQ-005 In IDLE with any req bit high, the block SHALL grant one requester at the rising edge by round-robin, starting the search at ptr, and SHALL set ptr to granted index + 1 mod NREQ.
REQ-006 At the grant edge the block SHALL capture the granted index and its op bit; later changes to req/op SHALL NOT affect the operation in flight.
REQ-007 If shadow_valid is 1 and the captured op equals q_shadow, the block SHALL go IDLE -> CHECK directly (elided: no s/r/en activity).
REQ-008 Otherwise the block SHALL go IDLE -> SETUP (1 cycle) -> PULSE (PULSE_LEN cycles) -> RELEASE (1 cycle) -> CHECK (1 cycle) -> IDLE.
REQ-009 SETUP: s = op, r = ~op, en = 0.
REQ-010 PULSE: s/r held as in SETUP, en = 1.
REQ-011 RELEASE: en = 0, s/r still held; IDLE and CHECK: s = r = en = 0.
REQ-012 s and r SHALL never both be 1, and SHALL change only in cycles where en = 0 both before and after the change.
REQ-013 In CHECK, ack[granted] SHALL be 1 for exactly that cycle; all other ack bits SHALL be 0.
REQ-014 Latency: ack is high PULSE_LEN+3 cycles after the grant edge (non-elided) and 1 cycle after it (elided).
REQ-015 On entry to CHECK (non-elided), q_shadow SHALL be set to the captured op and shadow_valid to 1.
REQ-016 In CHECK, if shadow_valid is 1 and q_in differs from q_shadow, err SHALL set and remain 1 until reset.
REQ-017 A requester dropping req before ack SHALL still receive its ack.
REQ-018 A requester holding req after ack SHALL be treated as a new request, subject to round-robin.
REQ-019 The block SHALL spend at least one cycle in IDLE between consecutive operations.

Reset
REQ-020 While rst_n = 0, the block SHALL force state = IDLE and s = r = en = 0, ack = 0, busy = 0, q_shadow = 0, shadow_valid = 0, err = 0, ptr = 0, all asynchronously.
REQ-021 Reset asserted mid-PULSE SHALL drop en in the same cycle, with no ack issued for the aborted operation.
REQ-022 The first operation after reset SHALL never be elided.

Verification
REQ-023 After reset, req = 0001 with op[0] = 1 (PULSE_LEN = 2) -> s = 1, r = 0; en high for 2 cycles; ack = 0001 5 cycles after grant; q_shadow = 1.
REQ-024 With q_shadow = 1 and shadow_valid = 1, req[2] set with op = 1 -> no en pulse, ack = 0100 one cycle after grant.
REQ-025 req = 1111 held continuously, alternating ops -> grants in order 0, 1, 2, 3, 0; no requester is starved; s & r is never 1.
REQ-026 Latch model with q_in stuck at 0, set operation -> err = 1 in the CHECK cycle and stays 1 through later good operations.
REQ-027 rst_n low during PULSE -> en = 0 immediately; no ack; after release, the next identical op is not elided.
REQ-028 req[1] dropped during SETUP -> the operation completes and ack[1] pulses once.
